// File: rtl/soc_bus_fabric.sv
// soc_bus_fabric: table-decoded, single-outstanding bus fabric between the CPU and N slaves,
// with a per-transaction timeout and sticky capture of unmapped or hung accesses.
module soc_bus_fabric #(
    parameter int unsigned              NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {4{32'hF000_0000}},
    parameter int unsigned              TIMEOUT_CYCLES = 255,
    parameter logic [31:0]              ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     mem_valid,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    input  logic [3:0]               mem_wstrb,
    output logic                     mem_ready,
    output logic [31:0]              mem_rdata,
    output logic [NUM_SLAVES-1:0]    s_valid,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    input  logic [NUM_SLAVES*32-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ready,
    input  logic                     err_clr,
    output logic                     bus_err,
    output logic                     err_valid,
    output logic [31:0]              err_addr,
    output logic [7:0]               err_count
);
    localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t                state_q, state_d;
    logic [NUM_SLAVES-1:0] s_valid_q, s_valid_d;
    logic [SW-1:0]         sel_q, sel_d, hit_idx;
    logic [31:0]           addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, err_addr_q, err_addr_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [7:0]            err_count_q, err_count_d;
    logic                  unmapped_q, unmapped_d, err_resp_q, err_resp_d, err_valid_q, err_valid_d;
    logic                  hit, rec_err;

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    // Unmapped requests still pass through ACTIVE (with no s_valid) so that error and
    // normal completions share the same two-cycle minimum latency.
    always_comb begin
        state_d    = state_q;
        s_valid_d  = s_valid_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        unmapped_d = unmapped_q;
        err_resp_d = err_resp_q;
        rec_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    addr_d     = mem_addr;
                    wdata_d    = mem_wdata;
                    wstrb_d    = mem_wstrb;
                    sel_d      = hit_idx;
                    unmapped_d = !hit;
                    s_valid_d  = hit ? NUM_SLAVES'(1) << hit_idx : '0;
                    cnt_d      = 16'(TIMEOUT_CYCLES);
                    state_d    = ACTIVE;
                end
            end
            ACTIVE: begin
                if (!unmapped_q && s_ready[sel_q]) begin
                    rdata_d    = s_rdata[32*sel_q +: 32];
                    s_valid_d  = '0;
                    err_resp_d = 1'b0;
                    state_d    = RESP;
                end else if (unmapped_q || cnt_q == 16'd1) begin
                    rdata_d    = ERR_RDATA;
                    s_valid_d  = '0;
                    err_resp_d = 1'b1;
                    rec_err    = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A clear in the same cycle as a new error is overridden by the record.
    always_comb begin
        err_valid_d = err_clr ? 1'b0 : err_valid_q;
        err_count_d = err_clr ? 8'd0 : err_count_q;
        err_addr_d  = err_addr_q;
        if (rec_err) begin
            err_addr_d  = err_valid_d ? err_addr_q : addr_q;
            err_valid_d = 1'b1;
            err_count_d = (err_count_d == 8'hFF) ? err_count_d : err_count_d + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            s_valid_q   <= '0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            unmapped_q  <= 1'b0;
            err_resp_q  <= 1'b0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            s_valid_q   <= s_valid_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            unmapped_q  <= unmapped_d;
            err_resp_q  <= err_resp_d;
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign mem_ready = state_q == RESP;
    assign bus_err   = mem_ready && err_resp_q;
    assign mem_rdata = rdata_q;
    assign s_valid   = s_valid_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign s_wstrb   = wstrb_q;
    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_soc_bus_fabric.sv
// tb_soc_bus_fabric: randomized bench for soc_bus_fabric against a decode-table and
// error-log model; a second instance with a short timeout covers the hung-slave path.
module tb_soc_bus_fabric;
    logic         clk = 1'b0, resetn = 1'b0;
    logic         mem_valid = 1'b0, err_clr = 1'b0;
    logic [31:0]  mem_addr = '0, mem_wdata = '0;
    logic [3:0]   mem_wstrb = '0, s_ready = '0, t_s_ready = '0;
    logic [127:0] s_rdata = '0;
    logic         mem_ready, bus_err, err_valid;
    logic [31:0]  mem_rdata, s_addr, s_wdata, err_addr;
    logic [3:0]   s_valid, s_wstrb;
    logic [7:0]   err_count;
    logic         t_mem_ready, t_bus_err, t_err_valid;
    logic [31:0]  t_mem_rdata, t_s_addr, t_s_wdata, t_err_addr;
    logic [3:0]   t_s_valid, t_s_wstrb;
    logic [7:0]   t_err_count;

    logic [31:0] base_tab [4] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
    logic [31:0] mask_tab [4] = '{32'hF000_0000, 32'hF000_0000, 32'hFF00_0000, 32'hF000_0000};

    int          tests = 0, fails = 0;
    bit          ev = 1'b0;
    logic [31:0] ea = '0;
    int          ec = 0;

    soc_bus_fabric #(
        .NUM_SLAVES(4),
        .SLAVE_BASE({32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000}),
        .SLAVE_MASK({32'hF000_0000, 32'hFF00_0000, 32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT_CYCLES(255),
        .ERR_RDATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rdata(s_rdata), .s_ready(s_ready), .err_clr(err_clr), .bus_err(bus_err),
        .err_valid(err_valid), .err_addr(err_addr), .err_count(err_count)
    );

    soc_bus_fabric #(
        .NUM_SLAVES(4),
        .SLAVE_BASE({32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000}),
        .SLAVE_MASK({32'hF000_0000, 32'hFF00_0000, 32'hF000_0000, 32'hF000_0000}),
        .TIMEOUT_CYCLES(4),
        .ERR_RDATA(32'hDEAD_BEEF)
    ) dut_t (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(t_mem_ready), .mem_rdata(t_mem_rdata),
        .s_valid(t_s_valid), .s_addr(t_s_addr), .s_wdata(t_s_wdata), .s_wstrb(t_s_wstrb),
        .s_rdata(s_rdata), .s_ready(t_s_ready), .err_clr(err_clr), .bus_err(t_bus_err),
        .err_valid(t_err_valid), .err_addr(t_err_addr), .err_count(t_err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & mask_tab[i]) == base_tab[i]) return i;
        return -1;
    endfunction

    // Issue one transaction; the slave answers dly cycles into s_valid with rd.
    // clr_at pulses err_clr in that cycle after acceptance (0 = never).
    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                           input int dly, input logic [31:0] rd, input int clr_at, input bit noise);
        int          sel, cyc, bad, exp_lat;
        bit          done;
        logic [3:0]  oh, exp_sv;
        logic [31:0] exp_rd, got_rd, got_ea;
        logic [7:0]  got_ec;
        logic        got_err, got_ev;
        sel     = decode(a);
        oh      = (sel >= 0) ? 4'(1 << sel) : 4'b0;
        exp_rd  = 32'hDEAD_BEEF;
        exp_lat = (sel >= 0) ? dly + 1 : 2;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
        @(posedge clk);
        #1 mem_valid = 1'b0; mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
        cyc = 0; bad = 0; done = 1'b0;
        got_rd = '0; got_err = 1'b0; got_ev = 1'b0; got_ea = '0; got_ec = '0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            s_ready = noise ? 4'($urandom) & ~oh : 4'b0;
            s_rdata = {$urandom, $urandom, $urandom, $urandom};
            err_clr = (cyc == clr_at);
            if (mem_ready) begin
                done = 1'b1; got_rd = mem_rdata; got_err = bus_err;
                got_ev = err_valid; got_ea = err_addr; got_ec = err_count;
            end else begin
                exp_sv = (sel >= 0 && cyc <= dly) ? oh : 4'b0;
                if (s_valid !== exp_sv) bad++;
                if (s_valid !== 4'b0 && (s_addr !== a || s_wdata !== wd || s_wstrb !== ws)) bad++;
                if (sel >= 0 && cyc == dly) begin
                    s_ready[sel] = 1'b1;
                    s_rdata[32*sel +: 32] = rd;
                    exp_rd = rd;
                end
            end
        end
        s_ready = '0; err_clr = 1'b0;
        if (clr_at > 0) begin ev = 1'b0; ec = 0; end
        if (sel < 0) begin
            if (!ev) ea = a;
            ev = 1'b1;
            ec = (ec < 255) ? ec + 1 : 255;
        end
        tests++; if (!done || cyc != exp_lat) begin fails++; $display("FAIL latency @%h: got %0d cycles done=%0d, expected %0d", a, cyc, done, exp_lat); end
        tests++; if (got_rd !== exp_rd) begin fails++; $display("FAIL rdata @%h: got %h expected %h", a, got_rd, exp_rd); end
        tests++; if (got_err !== (sel < 0)) begin fails++; $display("FAIL bus_err @%h: got %b expected %b", a, got_err, sel < 0); end
        tests++; if (bad != 0) begin fails++; $display("FAIL s_side @%h: %0d bad cycles, expected 0 (onehot %b)", a, bad, oh); end
        tests++; if (got_ev !== ev || got_ea !== ea || got_ec !== 8'(ec)) begin
            fails++;
            $display("FAIL errlog @%h: got v=%b a=%h c=%0d expected v=%b a=%h c=%0d", a, got_ev, got_ea, got_ec, ev, ea, ec);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL rst_mem_ready: got %b expected 0", mem_ready); end
        tests++; if (mem_rdata !== 32'h0) begin fails++; $display("FAIL rst_mem_rdata: got %h expected 0", mem_rdata); end
        tests++; if (s_valid !== 4'h0 || t_s_valid !== 4'h0) begin fails++; $display("FAIL rst_s_valid: got %b/%b expected 0", s_valid, t_s_valid); end
        tests++; if (s_addr !== 32'h0 || s_wdata !== 32'h0 || s_wstrb !== 4'h0) begin fails++; $display("FAIL rst_s_bus: got %h %h %h expected 0", s_addr, s_wdata, s_wstrb); end
        tests++; if (bus_err !== 1'b0 || err_valid !== 1'b0) begin fails++; $display("FAIL rst_err_flags: got %b %b expected 0", bus_err, err_valid); end
        tests++; if (err_addr !== 32'h0 || err_count !== 8'h0) begin fails++; $display("FAIL rst_err_log: got %h %0d expected 0 0", err_addr, err_count); end
        resetn = 1'b1;
        ev = 1'b0; ea = '0; ec = 0;
    endtask

    task automatic test_read;
        run_txn(32'h0000_0010, 32'h0, 4'b0000, 1, 32'h1234_5678, 0, 1'b0);
    endtask

    task automatic test_write;
        run_txn(32'h4000_0004, 32'hA5A5_0000, 4'b1100, 5, $urandom, 0, 1'b1);
        tests++; if (err_count !== 8'd0) begin fails++; $display("FAIL write_err_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_unmapped;
        run_txn(32'h7000_0000, 32'h0, 4'b0000, 1, $urandom, 0, 1'b1);
        tests++; if (err_addr !== 32'h7000_0000 || err_count !== 8'd1) begin fails++; $display("FAIL unmapped_log: got %h %0d expected 70000000 1", err_addr, err_count); end
    endtask

    task automatic test_err_capture;
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        ev = 1'b0; ec = 0;
        tests++; if (err_valid !== 1'b0 || err_count !== 8'd0 || err_addr !== ea) begin fails++; $display("FAIL clear: got v=%b c=%0d a=%h expected 0 0 %h", err_valid, err_count, err_addr, ea); end
        run_txn(32'h9000_0000, 32'h0, 4'b0000, 1, $urandom, 0, 1'b0);
        run_txn(32'h7000_0000, 32'h0, 4'b0000, 1, $urandom, 0, 1'b0);
        tests++; if (err_addr !== 32'h9000_0000 || err_count !== 8'd2) begin fails++; $display("FAIL first_err: got %h %0d expected 90000000 2", err_addr, err_count); end
        run_txn(32'hF123_4560, 32'h0, 4'b0000, 1, $urandom, 1, 1'b0);
        tests++; if (err_addr !== 32'hF123_4560 || err_count !== 8'd1 || err_valid !== 1'b1) begin fails++; $display("FAIL clr_vs_record: got %h %0d %b expected f1234560 1 1", err_addr, err_count, err_valid); end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 300; i++)
            run_txn({4'($urandom_range(1, 3)), 28'($urandom)}, $urandom, 4'($urandom), 1, $urandom, 0, 1'b1);
        tests++; if (err_count !== 8'd255) begin fails++; $display("FAIL saturation: got %0d expected 255", err_count); end
    endtask

    task automatic test_random_back_to_back;
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[27:24] = 4'h0;
            run_txn(a, $urandom, 4'($urandom), $urandom_range(1, 6), $urandom, $urandom_range(0, 1), 1'b1);
        end
    endtask

    task automatic test_timeout;
        int          cyc, hi, late;
        bit          done;
        logic [31:0] rd;
        logic        be;
        repeat (10) @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'hC000_0010; mem_wdata = $urandom; mem_wstrb = 4'b0000;
        @(posedge clk);
        #1 mem_valid = 1'b0;
        cyc = 0; hi = 0; done = 1'b0; rd = '0; be = 1'b0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (t_mem_ready) begin done = 1'b1; rd = t_mem_rdata; be = t_bus_err; end
            else if (t_s_valid === 4'b1000) hi++;
        end
        tests++; if (hi != 4 || cyc != 5 || !done) begin fails++; $display("FAIL timeout_shape: got hi=%0d lat=%0d expected 4 5", hi, cyc); end
        tests++; if (rd !== 32'hDEAD_BEEF || be !== 1'b1 || t_err_valid !== 1'b1) begin fails++; $display("FAIL timeout_resp: got %h err=%b v=%b expected deadbeef 1 1", rd, be, t_err_valid); end
        late = 0;
        t_s_ready = 4'b1000;
        repeat (6) begin @(negedge clk); if (t_mem_ready) late++; end
        t_s_ready = 4'b0000;
        tests++; if (late != 0 || t_s_valid !== 4'b0) begin fails++; $display("FAIL late_ready: got %0d extra mem_ready s_valid=%b expected 0 0", late, t_s_valid); end
    endtask

    task automatic test_reset_active;
        int rdy;
        logic [3:0] oh;
        oh = 4'(1 << decode(32'hC000_0010));
        tests++; if (s_valid !== oh) begin fails++; $display("FAIL hung_active: got %b expected %b", s_valid, oh); end
        @(negedge clk);
        resetn = 1'b0;
        #1;
        tests++; if (s_valid !== 4'b0) begin fails++; $display("FAIL async_abort: got %b expected 0", s_valid); end
        rdy = 0;
        repeat (3) begin @(negedge clk); if (mem_ready) rdy++; end
        resetn = 1'b1;
        ev = 1'b0; ea = '0; ec = 0;
        tests++; if (rdy != 0) begin fails++; $display("FAIL abort_ready: got %0d mem_ready expected 0", rdy); end
        run_txn(32'h0000_0020, 32'h0, 4'b0000, 2, $urandom, 0, 1'b1);
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_unmapped;
        test_err_capture;
        test_random_back_to_back;
        test_saturation;
        test_timeout;
        test_reset_active;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
